bram_arb_2p: RTL

- Arbiter that shares one 2^AW x DW simple-dual-port BRAM between two requesters: A (host load/unload) and B (NTT engine).
- The BRAM has a write port with write-address readback and a read port; both addresses are registered inside the RAM, so read data appears 1 cycle after the address.
- The block arbitrates the write channel and the read channel independently, steers addresses and data to the RAM, and returns tagged read-valid strobes to the winning requester.
- It sits between the NTT control logic and the BRAM instance.

---
 rtl/bram_arb_2p.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bram_arb_2p.sv
// Shares one simple-dual-port BRAM between requester A (host) and requester B (NTT engine).
// Write and read channels are arbitrated independently; read-valid strobes are returned one cycle after the grant.
module bram_arb_2p #(
    parameter int AW = 15,
    parameter int DW = 18,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_din,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_dout
);

    typedef struct packed {
        logic go;    // channel is granted to someone this cycle
        logic win;   // 0 = A, 1 = B
        logic lock;  // winner asked to keep the channel
    } arb_t;

    logic          r_wptr, r_rptr;
    logic          r_wlocked, r_rlocked;
    logic          r_wowner, r_rowner;
    logic          r_a_rvalid, r_b_rvalid;
    logic [AW-1:0] r_wr_addr, r_rd_addr;
    logic [DW-1:0] r_wr_din;
    arb_t          w_wr, w_rd;

    function automatic arb_t arbitrate(
        input logic en, input logic ra, input logic rb, input logic a_lk, input logic b_lk,
        input logic ptr, input logic locked, input logic owner
    );
        arb_t res;
        logic hold;
        // A locked owner keeps the channel only while it still asks for it with lock set.
        hold    = locked && (owner ? (rb && b_lk) : (ra && a_lk));
        res.go  = en && (ra || rb);
        if (hold)
            res.win = owner;
        else if (ra && rb)
            res.win = (RR != 0) ? ptr : 1'b0;
        else
            res.win = rb;
        res.lock = res.win ? b_lk : a_lk;
        return res;
    endfunction

    assign w_wr = arbitrate(rst_n, a_req && a_we, b_req && b_we, a_lock, b_lock,
                            r_wptr, r_wlocked, r_wowner);
    assign w_rd = arbitrate(rst_n, a_req && !a_we, b_req && !b_we, a_lock, b_lock,
                            r_rptr, r_rlocked, r_rowner);

    assign a_gnt = (w_wr.go && !w_wr.win) || (w_rd.go && !w_rd.win);
    assign b_gnt = (w_wr.go &&  w_wr.win) || (w_rd.go &&  w_rd.win);

    // Idle channels replay the last driven address/data so the RAM pins do not toggle.
    assign ram_wr_en   = w_wr.go;
    assign ram_wr_addr = w_wr.go ? (w_wr.win ? b_addr : a_addr) : r_wr_addr;
    assign ram_wr_din  = w_wr.go ? (w_wr.win ? b_din  : a_din)  : r_wr_din;
    assign ram_rd_addr = w_rd.go ? (w_rd.win ? b_addr : a_addr) : r_rd_addr;

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = ram_rd_dout;
    assign b_rdata  = ram_rd_dout;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_wlocked  <= 1'b0;
            r_rlocked  <= 1'b0;
            r_wowner   <= 1'b0;
            r_rowner   <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_din   <= '0;
            r_rd_addr  <= '0;
        end else begin
            r_a_rvalid <= w_rd.go && !w_rd.win;
            r_b_rvalid <= w_rd.go &&  w_rd.win;

            if (w_wr.go) begin
                r_wr_addr <= ram_wr_addr;
                r_wr_din  <= ram_wr_din;
                r_wlocked <= w_wr.lock;
                r_wowner  <= w_wr.win;
                // While locked the pointer parks on the other requester, ready for release.
                if (w_wr.lock || (w_wr.win == r_wptr))
                    r_wptr <= !w_wr.win;
            end else begin
                r_wlocked <= 1'b0;
            end

            if (w_rd.go) begin
                r_rd_addr <= ram_rd_addr;
                r_rlocked <= w_rd.lock;
                r_rowner  <= w_rd.win;
                if (w_rd.lock || (w_rd.win == r_rptr))
                    r_rptr <= !w_rd.win;
            end else begin
                r_rlocked <= 1'b0;
            end
        end
    end

endmodule
